ball_collision_detect: RTL and testbench
========================================

// Module: ball_collision_detect
// PURPOSE
// - Producer side of the ball collision interface: compares the raster position against the ball box and the object mask.
// - Emits per-pixel collision pulses with ball-edge flags: collision, ball_top/left/bottom/right_col.
// - Sits between the video timing/object renderers and ball_logic.
// - Also reports the first brick-pixel hit of each frame to the brick store over a valid/ready handshake.
// PARAMETERS
// - BALL_SIZE  4    ball edge length in pixels; square box, origin at top-left (ball_x, ball_y)
// - CNT_W      8    width of the debug collision counter (optional feature only)
// PORTS
// - clk           in   1   system/pixel clock
// - rst           in   1   synchronous reset, active-high
// - frame_pulse   in   1   1-cycle pulse at end of visible frame (same pulse ball_logic uses)
// - pix_active    in   1   raster is inside the visible area
// - pix_x         in   10  current raster column
// - pix_y         in   9   current raster row
// - obj_on        in   1   any solid object (wall/paddle/brick) covers this pixel
// - brick_on      in   1   a brick covers this pixel (subset of obj_on)
// - ball_x        in   10  ball position from ball_logic
// - ball_y        in   9   ball position from ball_logic
// - ball_on       out  1   ball covers the current pixel (for the drawing mux)
// - collision     out  1   registered collision pulse
// - ball_top_col, ball_left_col, ball_bottom_col, ball_right_col   out  1 each   edge flags qualifying collision
// - hit_valid     out  1   brick-hit record available
// - hit_ready     in   1   brick store accepts the record
// - hit_x         out  10  pixel column of the first brick hit in the frame
// - hit_y         out  9   pixel row of the first brick hit in the frame
// - hit_overrun   out  1   sticky: a brick hit was dropped because the record was still pending
// - col_count     out  CNT_W  collision pixels in the previous frame (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=1 at a clk edge) clears every register; all outputs read 0 the following cycle. Reset mid-frame discards a pending hit.
// - Shadow ball position
//   - bx/by load ball_x/ball_y on the cycle after frame_pulse, when ball_logic's update is visible.
//   - bx/by are also loaded during reset.
//   - All comparisons within a frame use bx/by; no tearing.
// - Ball box (combinational from shadow)
//   - in_box = pix_active & bx<=pix_x<=bx+BALL_SIZE-1 & by<=pix_y<=by+BALL_SIZE-1.
//   - Sums are computed 1 bit wider: no wrap at x=1023 or y=511.
//   - ball_on = in_box; combinational, zero latency.
// - Edge flags
//   - top = pix_y==by; bottom = pix_y==by+BALL_SIZE-1; left = pix_x==bx; right = pix_x==bx+BALL_SIZE-1.
//   - Corner pixels raise two flags.
//   - Interior pixels raise none but still count as a collision.
// - Outputs
//   - collision = in_box & obj_on, registered: 1-cycle latency.
//   - Edge flags are registered the same cycle and are 0 whenever collision=0.
//   - All collision outputs are forced 0 in the cycle frame_pulse is high, so ball_logic's clear is never lost.
// - Hit FSM, states IDLE -> ARMED -> PEND
//   - Any state -> ARMED on frame_pulse when hit_valid=0.
//   - ARMED: the first cycle with in_box & brick_on captures pix_x/pix_y into hit_x/hit_y, sets hit_valid=1, goes to PEND.
//   - PEND: hit_valid is held; hit_x/hit_y stay stable.
//   - PEND: the cycle with hit_valid & hit_ready clears hit_valid and goes to IDLE; no new capture until the next frame_pulse.
//   - Brick hit while in PEND, or frame_pulse while still PEND: set hit_overrun and stay in PEND. The old record wins.
//   - Simultaneous hit_ready and frame_pulse in PEND: the handshake completes, then ARMED. No overrun.
//   - hit_overrun clears only on rst.
// CONFIGURATION
// - Macro BALL_COL_DEBUG_EN.
// - Defined:
//   - An internal saturating counter counts registered collision cycles; it holds at 2^CNT_W-1.
//   - On frame_pulse the counter value is copied to col_count and the counter is cleared.
// - Undefined: counter not built; col_count is tied 0. Port list is identical in both builds.
// TESTING
// - Reset: rst high 2 cycles mid-frame with a pending hit -> all outputs 0; hit_valid 0 after release.
// - Ball (100,200), size 4, obj_on across row 200 x=100..103 -> collision pulses 1 cycle late.
//   - Top flag on all four pixels; left flag with x=100; right flag with x=103; bottom flag never.
// - ball_x changes 100->102 mid-frame -> box stays at x=100 until the cycle after frame_pulse, then moves to 102.
// - brick_on at (101,201) then (102,201), hit_ready low -> hit_valid=1, hit_x=101, hit_y=201.
//   - Second hit raises hit_overrun; record unchanged.
//   - hit_ready=1 -> valid drops next cycle.
// - Ball at (1022,510), size 4, raster at x=1023 -> in_box=1; no wrap to x=0.
// - BALL_COL_DEBUG_EN with 300 collision pixels in a frame -> col_count=255 after frame_pulse.
//   - Undefined build -> col_count=0.

Source files
------------

// File: rtl/ball_collision_detect.sv
// Ball collision producer: box test, edge flags, first brick hit per frame.
// Optional debug counter behind `BALL_COL_DEBUG_EN (col_count tied 0 when undefined).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   frame_pulse                   1-cycle end-of-visible-frame pulse
//   pix_active, pix_x, pix_y      raster position
//   obj_on, brick_on              object masks at the current pixel
//   ball_x, ball_y                ball position from ball_logic
//   ball_on                       combinational ball-box coverage
//   collision, ball_*_col         registered collision pulse and edge flags
//   hit_valid/hit_ready           brick-hit record handshake
//   hit_x, hit_y, hit_overrun     record and sticky drop flag
//   col_count                     collision cycles in the previous frame
module ball_collision_detect #(
  parameter int BALL_SIZE = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_pulse,
  input  logic             pix_active,
  input  logic [9:0]       pix_x,
  input  logic [8:0]       pix_y,
  input  logic             obj_on,
  input  logic             brick_on,
  input  logic [9:0]       ball_x,
  input  logic [8:0]       ball_y,
  output logic             ball_on,
  output logic             collision,
  output logic             ball_top_col,
  output logic             ball_left_col,
  output logic             ball_bottom_col,
  output logic             ball_right_col,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [9:0]       hit_x,
  output logic [8:0]       hit_y,
  output logic             hit_overrun,
  output logic [CNT_W-1:0] col_count
);

  localparam logic [10:0] SZX = 11'(BALL_SIZE - 1);
  localparam logic [9:0]  SZY = 10'(BALL_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_PEND
  } state_t;

  // Shadow ball position, frozen for the whole frame
  logic [9:0] bx_q;
  logic [8:0] by_q;
  logic       fp_q;

  // ball_logic updates at the frame_pulse edge, so the new
  // position is sampled one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      fp_q <= 1'b0;
      bx_q <= ball_x;
      by_q <= ball_y;
    end else begin
      fp_q <= frame_pulse;
      if (fp_q) begin
        bx_q <= ball_x;
        by_q <= ball_y;
      end
    end
  end

  // Box compare one bit wider so the far edge never wraps
  logic [10:0] px_w, bx_w, bx_end;
  logic [9:0]  py_w, by_w, by_end;
  logic        in_box;

  assign px_w   = {1'b0, pix_x};
  assign bx_w   = {1'b0, bx_q};
  assign bx_end = bx_w + SZX;
  assign py_w   = {1'b0, pix_y};
  assign by_w   = {1'b0, by_q};
  assign by_end = by_w + SZY;

  assign in_box = pix_active
                & (px_w >= bx_w) & (px_w <= bx_end)
                & (py_w >= by_w) & (py_w <= by_end);

  assign ball_on = in_box;

  // Collision and edge flags
  logic       coll_d, coll_q;
  logic [3:0] flg_d, flg_q;

  assign coll_d = in_box & obj_on;
  assign flg_d  = {py_w == by_w,
                   px_w == bx_w,
                   py_w == by_end,
                   px_w == bx_end} & {4{coll_d}};

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= 1'b0;
      flg_q  <= 4'b0;
    end else begin
      coll_q <= coll_d;
      flg_q  <= flg_d;
    end
  end

  // Suppressed during frame_pulse so ball_logic's clear wins
  assign collision       = coll_q   & ~frame_pulse;
  assign ball_top_col    = flg_q[3] & ~frame_pulse;
  assign ball_left_col   = flg_q[2] & ~frame_pulse;
  assign ball_bottom_col = flg_q[1] & ~frame_pulse;
  assign ball_right_col  = flg_q[0] & ~frame_pulse;

  // Brick hit FSM
  state_t     state_q, state_d;
  logic [9:0] hx_q, hx_d;
  logic [8:0] hy_q, hy_d;
  logic       ovr_q, ovr_d;
  logic       bhit;

  assign bhit = in_box & brick_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hx_q    <= 10'd0;
      hy_q    <= 9'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_PEND: begin
        if (hit_ready) begin
          // Handshake completes even alongside frame_pulse
          state_d = frame_pulse ? S_ARMED : S_IDLE;
        end else if (frame_pulse | bhit) begin
          ovr_d = 1'b1;
        end
      end
      S_ARMED: begin
        if (frame_pulse) begin
          state_d = S_ARMED;
        end else if (bhit) begin
          hx_d    = pix_x;
          hy_d    = pix_y;
          state_d = S_PEND;
        end
      end
      default: begin
        if (frame_pulse) state_d = S_ARMED;
      end
    endcase
  end

  assign hit_valid   = (state_q == S_PEND);
  assign hit_x       = hx_q;
  assign hit_y       = hy_q;
  assign hit_overrun = ovr_q;

`ifdef BALL_COL_DEBUG_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cc_q, cc_d;

  always_comb begin
    cnt_d = cnt_q;
    cc_d  = cc_q;
    if (frame_pulse) begin
      cc_d  = cnt_q;
      cnt_d = '0;
    end else if (collision && cnt_q != CMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      cc_q  <= cc_d;
    end
  end

  assign col_count = cc_q;
`else
  assign col_count = '0;
`endif

endmodule

// File: tb/tb_ball_collision_detect.sv
// Directed self-checking bench for ball_collision_detect.
// Checks box, flags, shadow timing, hit handshake, wrap, counter, reset.
module tb_ball_collision_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_pulse;
  logic       pix_active;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       obj_on;
  logic       brick_on;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_on;
  logic       collision;
  logic       top, left, bottom, right;
  logic       hit_valid;
  logic       hit_ready;
  logic [9:0] hit_x;
  logic [8:0] hit_y;
  logic       hit_overrun;
  logic [7:0] col_count;

  int n_chk = 0;
  int n_err = 0;

`ifdef BALL_COL_DEBUG_EN
  localparam int EXP_CNT = 255;
`else
  localparam int EXP_CNT = 0;
`endif

  ball_collision_detect #(
    .BALL_SIZE(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_pulse(frame_pulse),
    .pix_active(pix_active),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .obj_on(obj_on),
    .brick_on(brick_on),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .ball_on(ball_on),
    .collision(collision),
    .ball_top_col(top),
    .ball_left_col(left),
    .ball_bottom_col(bottom),
    .ball_right_col(right),
    .hit_valid(hit_valid),
    .hit_ready(hit_ready),
    .hit_x(hit_x),
    .hit_y(hit_y),
    .hit_overrun(hit_overrun),
    .col_count(col_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic a,
                         input int x, input int y);
    pix_active = a;
    pix_x      = 10'(x);
    pix_y      = 9'(y);
  endtask

  task automatic pulse_frame;
    frame_pulse = 1'b1;
    tick();
    frame_pulse = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    frame_pulse = 1'b0;
    obj_on      = 1'b0;
    brick_on    = 1'b0;
    hit_ready   = 1'b0;
    ball_x      = 10'd100;
    ball_y      = 9'd200;
    set_pix(1'b0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_coll", collision, 0);
    check("rst_valid", hit_valid, 0);
    check("rst_ovr", hit_overrun, 0);
    check("rst_cnt", col_count, 0);

    // Row 200 across the ball's top edge
    obj_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_pix(1'b1, 100 + i, 200);
      #1;
      check("ball_on", ball_on, i < 4);
      if (i == 0) check("latency", collision, 0);
      tick();
      check("row_coll", collision, i < 4);
      check("row_top", top, i < 4);
      check("row_left", left, i == 0);
      check("row_right", right, i == 3);
      check("row_bot", bottom, 0);
    end

    set_pix(1'b1, 101, 203);
    tick();
    check("bot_coll", collision, 1);
    check("bot_flag", bottom, 1);
    check("bot_top", top, 0);

    set_pix(1'b1, 101, 201);
    tick();
    check("int_coll", collision, 1);
    check("int_flags", {top, left, bottom, right}, 0);

    obj_on = 1'b0;
    tick();
    check("noobj", collision, 0);
    check("noobj_on", ball_on, 1);

    // Registered collision suppressed during frame_pulse
    obj_on = 1'b1;
    tick();
    check("pre_fp", collision, 1);
    set_pix(1'b0, 0, 0);
    obj_on      = 1'b0;
    frame_pulse = 1'b1;
    #1;
    check("fp_gate", collision, 0);
    check("fp_top", top, 0);
    tick();
    frame_pulse = 1'b0;
    tick();

    // Brick hits with the store stalled
    brick_on = 1'b1;
    set_pix(1'b1, 101, 201);
    tick();
    check("hit_v", hit_valid, 1);
    check("hit_x", hit_x, 101);
    check("hit_y", hit_y, 201);
    check("hit_ovr0", hit_overrun, 0);
    set_pix(1'b1, 102, 201);
    tick();
    check("ovr", hit_overrun, 1);
    check("ovr_x", hit_x, 101);
    check("ovr_v", hit_valid, 1);
    brick_on  = 1'b0;
    hit_ready = 1'b1;
    tick();
    check("hs_drop", hit_valid, 0);
    hit_ready = 1'b0;
    brick_on  = 1'b1;
    set_pix(1'b1, 101, 201);
    tick();
    check("no_recap", hit_valid, 0);
    check("ovr_stick", hit_overrun, 1);
    brick_on = 1'b0;

    // Shadow position holds until after frame_pulse
    ball_x = 10'd102;
    set_pix(1'b1, 100, 200);
    tick();
    #1;
    check("shadow_old", ball_on, 1);
    set_pix(1'b0, 0, 0);
    pulse_frame();
    set_pix(1'b1, 100, 200);
    #1;
    check("shadow_x100", ball_on, 0);
    set_pix(1'b1, 105, 200);
    #1;
    check("shadow_x105", ball_on, 1);

    // Far-corner ball, no wrap
    ball_x = 10'd1022;
    ball_y = 9'd510;
    set_pix(1'b0, 0, 0);
    pulse_frame();
    set_pix(1'b1, 1023, 510);
    #1;
    check("wrap_in", ball_on, 1);
    set_pix(1'b1, 0, 510);
    #1;
    check("wrap_x0", ball_on, 0);
    set_pix(1'b1, 1023, 511);
    #1;
    check("wrap_y511", ball_on, 1);
    set_pix(1'b1, 1023, 0);
    #1;
    check("wrap_y0", ball_on, 0);
    set_pix(1'b1, 1023, 510);
    obj_on = 1'b1;
    tick();
    check("wrap_top", top, 1);
    check("wrap_right", right, 0);
    check("wrap_left", left, 0);

    // 300 collision cycles in one frame
    for (int i = 0; i < 299; i++) tick();
    obj_on = 1'b0;
    set_pix(1'b0, 0, 0);
    tick();
    frame_pulse = 1'b1;
    tick();
    frame_pulse = 1'b0;
    #1;
    check("col_count", col_count, EXP_CNT);
    tick();

    // Reset mid-frame with a pending hit
    brick_on = 1'b1;
    set_pix(1'b1, 1023, 511);
    tick();
    check("pend_v", hit_valid, 1);
    check("pend_x", hit_x, 1023);
    check("pend_y", hit_y, 511);
    brick_on = 1'b0;
    set_pix(1'b0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    check("r2_valid", hit_valid, 0);
    check("r2_coll", collision, 0);
    check("r2_ovr", hit_overrun, 0);
    check("r2_hx", hit_x, 0);
    check("r2_cnt", col_count, 0);
    check("r2_on", ball_on, 0);
    rst = 1'b0;
    tick();
    check("r2_post", hit_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
